mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port backing memory between the pipeline's instruction-fetch port and its data port.
//  Sits between the cpu core (PC/INSTRUCTION, DATA_MEM_* ports) and the unified memory.
//  Grants one requester at a time, holds the request stable until the memory completes, and returns busywait/read data per port.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive data grants while IF waits before IF is forced to win (1..15)
// PORTS
//  CLK                  in   1   system clock, all state on posedge
//  RESET                in   1   synchronous, active-high reset
//  IF_READ              in   1   instruction fetch request
//  IF_ADDR              in   32  fetch address (PC)
//  IF_READDATA          out  32  fetched instruction
//  IF_BUSYWAIT          out  1   fetch not yet complete
//  D_READ               in   4   {en, funct3}: LB/LH/LW/LBU/LHU encoding
//  D_WRITE              in   3   {en, size[1:0]}: SB/SH/SW encoding
//  D_ADDR               in   32  data address
//  D_WRITEDATA          in   32  store data
//  D_READDATA           out  32  load data
//  D_BUSYWAIT           out  1   data access not yet complete
//  MEM_READ             out  4   to memory, same encoding as D_READ
//  MEM_WRITE            out  3   to memory, same encoding as D_WRITE
//  MEM_ADDR             out  32  to memory
//  MEM_WRITEDATA        out  32  to memory
//  MEM_READDATA         in   32  from memory
//  MEM_BUSYWAIT         in   1   memory busy; low = access completes this cycle
// BEHAVIOUR
//  - Reset values: state IDLE; MEM_READ=0, MEM_WRITE=0, MEM_ADDR=0, MEM_WRITEDATA=0; starve_cnt=0; rr_last=0.
//  - IF_BUSYWAIT/D_BUSYWAIT are 0 while RESET=1.
//  - Request present: if_req=IF_READ; d_req=D_READ[3]|D_WRITE[2]. D_READ[3]&D_WRITE[2] together is illegal; write wins.
//  - FSM IDLE -> SERVE_I | SERVE_D -> IDLE.
//    - IDLE: pick a winner, register its addr/data/ctrl into the MEM_* outputs, go to SERVE_x.
//    - IF is sent as MEM_READ=4'b1010 (LW) and MEM_WRITE=0.
//    - SERVE_x: MEM_* are held constant. When MEM_BUSYWAIT=0: complete, clear MEM_READ/MEM_WRITE at that edge, go to IDLE.
//  - Completion cycle: the served port's BUSYWAIT=0 and its READDATA=MEM_READDATA, same cycle combinational. The requester samples at the closing edge.
//  - x_BUSYWAIT = x_req & ~(state==SERVE_x & ~MEM_BUSYWAIT). This is high in IDLE, the grant cycle and the other port's service.
//  - READDATA outputs: hold the last completed value (0 after reset) when not completing.
//  - Minimum latency per access is 2 cycles (IDLE grant + 1 SERVE cycle with MEM_BUSYWAIT=0). There is always 1 IDLE cycle between back-to-back grants.
//  - Arbitration (fixed mode): data wins over IF.
//    - Exception: when starve_cnt==STARVE_LIMIT, IF wins.
//    - starve_cnt++ on each data grant while if_req=1, saturating at STARVE_LIMIT.
//    - starve_cnt is cleared on any IF grant or when if_req=0 in IDLE.
//  - A request withdrawn mid-service does not abort: the latched access completes and its result is discarded. A write is still performed.
//  - Address/data changes during SERVE are ignored because the outputs are registered.
//  - RESET asserted mid-SERVE: the access is abandoned and MEM_READ/MEM_WRITE go to 0 at that edge.
// CONFIGURATION
//  - MEM_ARB_RR_EN defined: when both ports request in IDLE, the grant alternates.
//    - The winner is the port not granted last (rr_last: 0=IF, 1=D). rr_last updates on every grant.
//    - The starvation counter and STARVE_LIMIT are unused, and starve_cnt is held at 0.
//  - MEM_ARB_RR_EN undefined: fixed data priority with the starvation override described above.
// STRUCTURE
//  - Shared header mem_arb_defs.vh: state codes (IDLE=2'd0, SERVE_I=2'd1, SERVE_D=2'd2) and IF_READ_CODE=4'b1010.
//  - The header also holds READ_EN_BIT=3 and WRITE_EN_BIT=2.
//  - One sub-module mem_arb_pick: combinational winner select.
//    - Inputs: if_req, d_req, starve_full, rr_last.
//    - Outputs: grant_i, grant_d. The MEM_ARB_RR_EN choice is made inside it.
//  - FSM, output registers, counters and busywait logic stay in mem_arbiter.
// TESTING
//  - Single fetch: IF_READ=1, IF_ADDR=0x40, mem returns 0x00500093 with 1 busy cycle.
//    -> MEM_READ=1010 for 2 cycles, IF_BUSYWAIT low in the cycle MEM_BUSYWAIT=0, IF_READDATA=0x00500093.
//  - Simultaneous requests: IF_READ=1 and D_READ=4'b1010 at addr 0x100 in the same cycle.
//    -> data served first, MEM_ADDR=0x100; IF served next with MEM_ADDR=IF_ADDR after 1 IDLE cycle.
//    -> with MEM_ARB_RR_EN, the order alternates on repeated collisions.
//  - Starvation: D_WRITE=3'b110 held continuously with IF_READ=1, STARVE_LIMIT=4.
//    -> 4 data grants, then IF granted, then counter back to 0.
//  - Store: D_WRITE=3'b110 (SW), D_ADDR=0x200, D_WRITEDATA=0xDEADBEEF.
//    -> MEM_WRITE=110, MEM_WRITEDATA=0xDEADBEEF stable through MEM_BUSYWAIT=1 for 3 cycles, then cleared.
//  - Withdrawal: drop D_READ after grant -> access completes, MEM_READ cleared on completion, and D_BUSYWAIT stays 0.
//  - Reset mid-SERVE_D: RESET=1 for 1 cycle -> next cycle MEM_READ=0, MEM_WRITE=0, state IDLE, both BUSYWAIT=0 during reset.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// State codes, the fetch command encoding and request-enable bit positions.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    localparam logic [3:0] IF_READ_CODE = 4'b1010;
    localparam int         READ_EN_BIT  = 3;
    localparam int         WRITE_EN_BIT = 2;

    // Increment that sticks at the limit instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] cnt, input logic [3:0] limit);
        return (cnt >= limit) ? cnt : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner select for the memory arbiter.
// MEM_ARB_RR_EN selects alternating grants; otherwise data wins unless IF is starved.
import mem_arbiter_pkg::*;

module mem_arb_pick (
    input  logic if_req,
    input  logic d_req,
    input  logic starve_full,
    input  logic rr_last,
    output logic grant_i,
    output logic grant_d
);

    logic unused_s;

`ifdef MEM_ARB_RR_EN
    assign unused_s = starve_full;

    // On a collision the port that did not win last time goes first.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (if_req && d_req) begin
            grant_i = rr_last;
            grant_d = ~rr_last;
        end else begin
            grant_i = if_req;
            grant_d = d_req;
        end
    end
`else
    assign unused_s = rr_last;

    // Data has priority; a saturated starvation count hands the collision to IF.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (if_req && d_req) begin
            grant_i = starve_full;
            grant_d = ~starve_full;
        end else begin
            grant_i = if_req;
            grant_d = d_req;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports of the core.
// Define MEM_ARB_RR_EN for alternating grants instead of data priority with starvation override.
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IF_READ,
    input  logic [31:0] IF_ADDR,
    output logic [31:0] IF_READDATA,
    output logic        IF_BUSYWAIT,
    input  logic [3:0]  D_READ,
    input  logic [2:0]  D_WRITE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WRITEDATA,
    output logic [31:0] D_READDATA,
    output logic        D_BUSYWAIT,
    output logic [3:0]  MEM_READ,
    output logic [2:0]  MEM_WRITE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    arb_state_t  state_r;
    logic [3:0]  starve_cnt_r;
    logic        rr_last_r;
    logic [31:0] if_rdata_r;
    logic [31:0] d_rdata_r;

    logic if_req_s;
    logic d_req_s;
    logic d_is_write_s;
    logic starve_full_s;
    logic grant_i_s;
    logic grant_d_s;
    logic complete_i_s;
    logic complete_d_s;

    assign if_req_s      = IF_READ;
    assign d_is_write_s  = D_WRITE[WRITE_EN_BIT];
    assign d_req_s       = D_READ[READ_EN_BIT] | d_is_write_s;
    assign starve_full_s = (starve_cnt_r == 4'(STARVE_LIMIT));
    assign complete_i_s  = (state_r == SERVE_I) & ~MEM_BUSYWAIT;
    assign complete_d_s  = (state_r == SERVE_D) & ~MEM_BUSYWAIT;

    // Busywait drops only in the completion cycle of the port being served.
    assign IF_BUSYWAIT = ~RESET & if_req_s & ~complete_i_s;
    assign D_BUSYWAIT  = ~RESET & d_req_s & ~complete_d_s;
    assign IF_READDATA = complete_i_s ? MEM_READDATA : if_rdata_r;
    assign D_READDATA  = complete_d_s ? MEM_READDATA : d_rdata_r;

    mem_arb_pick u_pick (
        .if_req      (if_req_s),
        .d_req       (d_req_s),
        .starve_full (starve_full_s),
        .rr_last     (rr_last_r),
        .grant_i     (grant_i_s),
        .grant_d     (grant_d_s)
    );

    // Grant/serve FSM with registered memory command and starvation bookkeeping.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r       <= IDLE;
            MEM_READ      <= 4'd0;
            MEM_WRITE     <= 3'd0;
            MEM_ADDR      <= 32'd0;
            MEM_WRITEDATA <= 32'd0;
            starve_cnt_r  <= 4'd0;
            rr_last_r     <= 1'b0;
            if_rdata_r    <= 32'd0;
            d_rdata_r     <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_d_s) begin
                        MEM_READ      <= d_is_write_s ? 4'd0 : D_READ;
                        MEM_WRITE     <= d_is_write_s ? D_WRITE : 3'd0;
                        MEM_ADDR      <= D_ADDR;
                        MEM_WRITEDATA <= D_WRITEDATA;
                        rr_last_r     <= 1'b1;
                        state_r       <= SERVE_D;
`ifdef MEM_ARB_RR_EN
                        starve_cnt_r  <= 4'd0;
`else
                        starve_cnt_r  <= if_req_s ? sat_inc4(starve_cnt_r, 4'(STARVE_LIMIT)) : 4'd0;
`endif
                    end else if (grant_i_s) begin
                        MEM_READ      <= IF_READ_CODE;
                        MEM_WRITE     <= 3'd0;
                        MEM_ADDR      <= IF_ADDR;
                        rr_last_r     <= 1'b0;
                        starve_cnt_r  <= 4'd0;
                        state_r       <= SERVE_I;
                    end else begin
                        starve_cnt_r  <= 4'd0;
                    end
                end
                SERVE_I: begin
                    if (!MEM_BUSYWAIT) begin
                        MEM_READ   <= 4'd0;
                        MEM_WRITE  <= 3'd0;
                        if_rdata_r <= MEM_READDATA;
                        state_r    <= IDLE;
                    end
                end
                SERVE_D: begin
                    if (!MEM_BUSYWAIT) begin
                        MEM_READ  <= 4'd0;
                        MEM_WRITE <= 3'd0;
                        d_rdata_r <= MEM_READDATA;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    MEM_READ  <= 4'd0;
                    MEM_WRITE <= 3'd0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
